tdm_demux: RTL



---
 rtl/tdm_demux_if.sv | 16 +
 rtl/tdm_demux.sv | 89 ++++++++
 2 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial TDM input and parallel frame output bundle for tdm_demux
// en/din/sync: bit strobe, serial bit and frame marker (driven by master)
// ch_data/frame_valid/sync_err: reassembled frame, update pulse, framing error pulse (driven by slave)
interface tdm_demux_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic                    en;
  logic                    din;
  logic                    sync;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic                    frame_valid;
  logic                    sync_err;
  modport master (output en, din, sync, input ch_data, frame_valid, sync_err);
  modport slave (input en, din, sync, output ch_data, frame_valid, sync_err);
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM demultiplexer, reassembles NUM_CH MSB-first WIDTH-bit slots per sync-aligned frame
// clk, rst_n: rising-edge clock, asynchronous active-low reset
// bus.en/din/sync: bit strobe, serial data, frame marker on slot 0 MSB
// bus.ch_data: all channels, channel k at [k*WIDTH +: WIDTH], updated atomically per frame
// bus.frame_valid/sync_err: one-cycle pulses on frame completion / framing error
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux_if.slave  bus
);
  localparam int BW = WIDTH > 2 ? $clog2(WIDTH) : 1;
  localparam int SW = NUM_CH > 2 ? $clog2(NUM_CH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CH - 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t                           state, state_d;
  logic [WIDTH-2:0]                 shreg;
  logic [BW-1:0]                    bit_cnt;
  logic [SW-1:0]                    slot_cnt;
  logic [NUM_CH-2:0][WIDTH-1:0]     hold;
  logic [WIDTH-1:0]                 word;
  logic                             boundary, last_bit, last_slot;
  logic                             start, shift, fv_d, se_d;
  assign word      = {shreg, bus.din};
  assign boundary  = bit_cnt == '0 && slot_cnt == '0;
  assign last_bit  = bit_cnt == BIT_LAST;
  assign last_slot = slot_cnt == SLOT_LAST;
  // start: the sampled bit opens a new frame; shift: the bit continues the current one
  always_comb begin
    state_d = state;
    start   = 1'b0;
    shift   = 1'b0;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (bus.en) begin
      if (state == IDLE) begin
        start   = bus.sync;
        state_d = bus.sync ? RECV : IDLE;
      end else if (boundary) begin
        start   = bus.sync;
        se_d    = !bus.sync;
        state_d = bus.sync ? RECV : IDLE;
      end else if (bus.sync) begin
        start = 1'b1;
        se_d  = 1'b1;
      end else begin
        shift = 1'b1;
        fv_d  = last_bit && last_slot;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
    end else begin
      state           <= state_d;
      bus.frame_valid <= fv_d;
      bus.sync_err    <= se_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      hold        <= '0;
      bus.ch_data <= '0;
    end else if (start) begin
      shreg    <= (WIDTH-1)'(bus.din);
      bit_cnt  <= BW'(1);
      slot_cnt <= '0;
    end else if (shift) begin
      shreg <= word[WIDTH-2:0];
      if (last_bit) begin
        bit_cnt  <= '0;
        slot_cnt <= last_slot ? '0 : slot_cnt + 1'b1;
        if (last_slot) bus.ch_data <= {word, hold};
        else hold[slot_cnt] <= word;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule
